// File: rtl/nand_flash_target.sv
// rtl/nand_flash_target.sv - x8 async NAND die responder with page register and small array
module nand_flash_target #(
    parameter int         PAGE_BYTES = 16,
    parameter int         PAGES      = 16,
    parameter int         T_READ_CYC = 32,
    parameter int         T_PROG_CYC = 128,
    parameter int         T_RST_CYC  = 8,
    parameter logic [7:0] ID0        = 8'hEC,
    parameter logic [7:0] ID1        = 8'hD3,
    parameter logic [7:0] IDLEDATA   = 8'hAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iCE_N,
    input  logic       iCLE,
    input  logic       iALE,
    input  logic       iWE_N,
    input  logic       iRE_N,
    input  logic       iWP_N,
    input  logic [7:0] flash_data,
    output logic [7:0] flash_q,
    output logic       q_oe,
    output logic       oRB_N
);
    localparam int CB    = $clog2(PAGE_BYTES);
    localparam int RB    = $clog2(PAGES);
    localparam int XW    = CB + 1;
    localparam int T_RP  = (T_READ_CYC > T_PROG_CYC) ? T_READ_CYC : T_PROG_CYC;
    localparam int T_MAX = (T_RP > T_RST_CYC) ? T_RP : T_RST_CYC;
    localparam int CW    = $clog2(T_MAX) + 1;

    localparam logic [7:0] CMD_READ1  = 8'h00;
    localparam logic [7:0] CMD_READ2  = 8'h30;
    localparam logic [7:0] CMD_PROG1  = 8'h80;
    localparam logic [7:0] CMD_PROG2  = 8'h10;
    localparam logic [7:0] CMD_ID     = 8'h90;
    localparam logic [7:0] CMD_STATUS = 8'h70;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_ADDR, S_RD_BUSY, S_RD_OUT, S_PG_ADDR, S_PG_LOAD,
        S_PG_BUSY, S_ID_ADDR, S_ID_OUT, S_ST_OUT, S_RST_BUSY
    } state_t;

    // The array operation runs independently of the state so that a status
    // read can park the FSM in S_ST_OUT while the timer keeps counting.
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_PROG, OP_RST} op_t;

    state_t          state, state_n;
    op_t             op, op_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   load_val;
    logic            load_cnt;
    logic [XW-1:0]   xfer;
    logic [CB-1:0]   xidx;
    logic [CB-1:0]   col;
    logic [RB-1:0]   row;
    logic [1:0]      addr_cnt;
    logic            id_ptr;
    logic            fail;

    logic            s1_ce, s1_cle, s1_ale, s1_we, s1_re, s1_wp;
    logic [7:0]      s1_data;
    logic            s2_we, s2_re;

    logic [7:0]      page_reg [0:PAGE_BYTES-1];
    logic [7:0]      mem      [0:PAGES*PAGE_BYTES-1];

    logic            we_rise, re_fall, re_rise;
    logic            cmd_ev, addr_ev, data_ev;
    logic            busy, busy_n, out_state, rd_en, enter_addr, pg_fill;
    logic [7:0]      status, out_byte;

    assign we_rise   = s1_we & ~s2_we;
    assign re_fall   = ~s1_re & s2_re;
    assign re_rise   = s1_re & ~s2_re;
    assign cmd_ev    = we_rise & ~s1_ce & s1_cle & ~s1_ale;
    assign addr_ev   = we_rise & ~s1_ce & s1_ale & ~s1_cle;
    assign data_ev   = we_rise & ~s1_ce & ~s1_cle & ~s1_ale;
    assign busy      = (op != OP_NONE);
    assign busy_n    = (op_n != OP_NONE);
    assign xidx      = xfer[CB-1:0];
    assign status    = {s1_wp, ~busy, 5'b0, fail};
    assign out_state = (state == S_RD_OUT) || (state == S_ID_OUT) || (state == S_ST_OUT);
    assign rd_en     = ~s1_ce & ~s1_re & out_state;
    assign enter_addr = cmd_ev && ((state_n == S_RD_ADDR) || (state_n == S_PG_ADDR) ||
                                   (state_n == S_ID_ADDR));
    assign pg_fill   = cmd_ev && (state_n == S_PG_ADDR);

    function automatic state_t decode(input logic [7:0] c);
        case (c)
            CMD_READ1: decode = S_RD_ADDR;
            CMD_PROG1: decode = S_PG_ADDR;
            CMD_ID:    decode = S_ID_ADDR;
            default:   decode = S_IDLE;
        endcase
    endfunction

    always_comb begin
        state_n  = state;
        op_n     = op;
        load_cnt = 1'b0;
        load_val = '0;
        if (busy && cnt == '0) begin
            op_n = OP_NONE;
            case (state)
                S_RD_BUSY:             state_n = S_RD_OUT;
                S_PG_BUSY, S_RST_BUSY: state_n = S_IDLE;
                default:               state_n = state;
            endcase
        end
        if (cmd_ev) begin
            if (s1_data == CMD_RESET) begin
                state_n  = S_RST_BUSY;
                op_n     = OP_RST;
                load_cnt = 1'b1;
                load_val = CW'(T_RST_CYC);
            end else if (s1_data == CMD_STATUS) begin
                state_n = S_ST_OUT;
            end else if (!busy) begin
                if (state == S_RD_ADDR && s1_data == CMD_READ2 && addr_cnt == 2'd2) begin
                    state_n  = S_RD_BUSY;
                    op_n     = OP_READ;
                    load_cnt = 1'b1;
                    load_val = CW'(T_READ_CYC);
                end else if (state == S_PG_LOAD && s1_data == CMD_PROG2) begin
                    state_n  = S_PG_BUSY;
                    op_n     = OP_PROG;
                    load_cnt = 1'b1;
                    load_val = CW'(T_PROG_CYC);
                end else begin
                    state_n = decode(s1_data);
                end
            end
        end else if (addr_ev) begin
            if (state == S_PG_ADDR && addr_cnt == 2'd1)
                state_n = S_PG_LOAD;
            else if (state == S_ID_ADDR)
                state_n = S_ID_OUT;
        end
    end

    always_comb begin
        case (state)
            S_RD_OUT: out_byte = page_reg[col];
            S_ID_OUT: out_byte = id_ptr ? ID1 : ID0;
            S_ST_OUT: out_byte = status;
            default:  out_byte = IDLEDATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ce    <= 1'b1;
            s1_cle   <= 1'b0;
            s1_ale   <= 1'b0;
            s1_we    <= 1'b1;
            s1_re    <= 1'b1;
            s1_wp    <= 1'b1;
            s1_data  <= '0;
            s2_we    <= 1'b1;
            s2_re    <= 1'b1;
            state    <= S_IDLE;
            op       <= OP_NONE;
            cnt      <= '0;
            xfer     <= '0;
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
            id_ptr   <= 1'b0;
            fail     <= 1'b0;
            oRB_N    <= 1'b1;
            q_oe     <= 1'b0;
            flash_q  <= IDLEDATA;
        end else begin
            s1_ce   <= iCE_N;
            s1_cle  <= iCLE;
            s1_ale  <= iALE;
            s1_we   <= iWE_N;
            s1_re   <= iRE_N;
            s1_wp   <= iWP_N;
            s1_data <= flash_data;
            s2_we   <= s1_we;
            s2_re   <= s1_re;
            state   <= state_n;
            op      <= op_n;
            oRB_N   <= ~(busy & busy_n);

            if (load_cnt) begin
                cnt  <= load_val;
                xfer <= '0;
            end else begin
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
                if (busy && !xfer[XW-1])
                    xfer <= xfer + 1'b1;
            end

            if (enter_addr) begin
                addr_cnt <= '0;
                id_ptr   <= 1'b0;
            end
            if (cmd_ev && s1_data == CMD_RESET)
                fail <= 1'b0;
            else if (load_cnt && op_n == OP_PROG)
                fail <= ~s1_wp;

            if (addr_ev && (state == S_RD_ADDR || state == S_PG_ADDR)) begin
                if (addr_cnt == 2'd0)
                    col <= s1_data[CB-1:0];
                else if (addr_cnt == 2'd1)
                    row <= s1_data[RB-1:0];
                if (addr_cnt != 2'd2)
                    addr_cnt <= addr_cnt + 2'd1;
            end
            if (data_ev && state == S_PG_LOAD)
                col <= col + 1'b1;
            if (re_rise && !s1_ce) begin
                if (state == S_RD_OUT)
                    col <= col + 1'b1;
                else if (state == S_ID_OUT)
                    id_ptr <= ~id_ptr;
            end

            q_oe <= rd_en;
            if (!rd_en)
                flash_q <= IDLEDATA;
            else if (re_fall)
                flash_q <= out_byte;
        end
    end

    // Storage is not reset; a reset mid-program must still suppress the write.
    always_ff @(posedge clk) begin
        if (!rst && op == OP_PROG && !fail && !xfer[XW-1])
            mem[{row, xidx}] <= page_reg[xidx];
        if (op == OP_READ && !xfer[XW-1]) begin
            page_reg[xidx] <= mem[{row, xidx}];
        end else if (pg_fill) begin
            for (int i = 0; i < PAGE_BYTES; i++)
                page_reg[i] <= 8'hFF;
        end else if (data_ev && state == S_PG_LOAD) begin
            page_reg[col] <= s1_data;
        end
    end
endmodule

// File: tb/tb_nand_flash_target.sv
// tb/tb_nand_flash_target.sv - randomized bench for nand_flash_target against a page-level model
module tb_nand_flash_target;
    localparam int PB  = 16;
    localparam int NP  = 16;
    localparam int TR  = 32;
    localparam int TP  = 128;
    localparam int TRS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce_n = 1'b1, cle = 1'b0, ale = 1'b0, we_n = 1'b1, re_n = 1'b1, wp_n = 1'b1;
    logic [7:0] data = 8'h00;
    logic [7:0] flash_q;
    logic       q_oe, rb_n;

    int tests = 0;
    int failed = 0;
    int low_total = 0;
    int t_snap = 0;

    logic [7:0] model [NP][PB];
    bit         valid [NP];
    logic [7:0] buf_d [32];

    nand_flash_target dut (
        .clk(clk), .rst(rst), .iCE_N(ce_n), .iCLE(cle), .iALE(ale), .iWE_N(we_n),
        .iRE_N(re_n), .iWP_N(wp_n), .flash_data(data), .flash_q(flash_q), .q_oe(q_oe),
        .oRB_N(rb_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rb_n) low_total <= low_total + 1;

    initial begin
        #5000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic c, input logic a, input logic [7:0] d);
        data = d; cle = c; ale = a; we_n = 1'b0;
        tick(2);
        we_n = 1'b1;
        tick(3);
        cle = 1'b0; ale = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d);  wr(1'b1, 1'b0, d); endtask
    task automatic adr(input logic [7:0] d);  wr(1'b0, 1'b1, d); endtask
    task automatic dat(input logic [7:0] d);  wr(1'b0, 1'b0, d); endtask

    task automatic read_byte(output logic [7:0] q, output logic oe);
        re_n = 1'b0;
        tick(4);
        @(negedge clk);
        q = flash_q; oe = q_oe;
        @(posedge clk); #1;
        re_n = 1'b1;
        tick(3);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rb_n) break;
        end
        chk(tag, rb_n, 1'b1);
        tick(1);
    endtask

    // Upper address bits are randomized to show they are ignored.
    task automatic send_addr(input int col, input int row);
        adr(8'(col + PB * $urandom_range(0, 15)));
        adr(8'(row + NP * $urandom_range(0, 15)));
    endtask

    task automatic program_start(input int row, input int col, input int n);
        logic [7:0] pg [PB];
        cmd(8'h80);
        send_addr(col, row);
        for (int i = 0; i < n; i++) dat(buf_d[i]);
        t_snap = low_total;
        cmd(8'h10);
        for (int i = 0; i < PB; i++) pg[i] = 8'hFF;
        for (int i = 0; i < n; i++) pg[(col + i) % PB] = buf_d[i];
        if (wp_n) begin
            for (int i = 0; i < PB; i++) model[row][i] = pg[i];
            valid[row] = 1'b1;
        end
    endtask

    task automatic read_start(input int row, input int col);
        cmd(8'h00);
        send_addr(col, row);
        t_snap = low_total;
        cmd(8'h30);
        wait_ready("rd_ready", 4 * TR);
        chk("rd_busy_cycles", low_total - t_snap, TR);
    endtask

    task automatic check_read(input int row, input int col, input int n);
        logic [7:0] q;
        logic       oe;
        for (int i = 0; i < n; i++) begin
            read_byte(q, oe);
            chk("rd_data", q, model[row][(col + i) % PB]);
            chk("rd_oe", oe, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] q;
        logic       oe;
        int row, col, n, t1;

        for (int r = 0; r < NP; r++) valid[r] = 1'b0;
        tick(4);
        ce_n = 1'b0;
        rst = 1'b0;
        tick(2);
        chk("rst_flash_q", flash_q, 8'hAA);
        chk("rst_q_oe", q_oe, 1'b0);
        chk("rst_rb_n", rb_n, 1'b1);

        // Read ID
        t1 = low_total;
        cmd(8'h90);
        adr(8'h00);
        read_byte(q, oe); chk("id0", q, 8'hEC); chk("id_oe", oe, 1'b1);
        read_byte(q, oe); chk("id1", q, 8'hD3);
        read_byte(q, oe); chk("id0_again", q, 8'hEC);
        chk("id_no_busy", low_total - t1, 0);

        // Directed program/readback
        for (int i = 0; i < 4; i++) buf_d[i] = 8'(8'h11 + i);
        program_start(5, 0, 4);
        wait_ready("pg_ready", 4 * TP);
        chk("pg_busy_cycles", low_total - t_snap, TP);
        read_start(5, 0);
        check_read(5, 0, 5);

        // Randomized program / readback against the page model
        for (int it = 0; it < 6; it++) begin
            row = $urandom_range(0, NP - 1);
            col = $urandom_range(0, PB - 1);
            n   = $urandom_range(0, PB + 3);
            for (int i = 0; i < n; i++) buf_d[i] = 8'($urandom);
            program_start(row, col, n);
            wait_ready("rnd_pg_ready", 4 * TP);
            chk("rnd_pg_busy", low_total - t_snap, TP);
            if ($urandom_range(0, 1) == 1) begin
                int r2;
                r2 = $urandom_range(0, NP - 1);
                if (valid[r2]) row = r2;
            end
            col = $urandom_range(0, PB - 1);
            read_start(row, col);
            check_read(row, col, $urandom_range(1, PB + 4));
        end

        // Status while programming, then after completion with no new command
        for (int i = 0; i < 3; i++) buf_d[i] = 8'(8'h60 + i);
        program_start(6, 2, 3);
        tick(5);
        cmd(8'h70);
        read_byte(q, oe); chk("status_busy", q, 8'h80); chk("status_oe", oe, 1'b1);
        wait_ready("st_pg_ready", 4 * TP);
        chk("st_pg_busy", low_total - t_snap, TP);
        read_byte(q, oe); chk("status_done", q, 8'hC0);
        read_start(6, 0);
        check_read(6, 0, PB);

        // Write protect
        program_start(3, 0, 0);
        wait_ready("wp_prefill_ready", 4 * TP);
        wp_n = 1'b0;
        for (int i = 0; i < 4; i++) buf_d[i] = 8'(8'h30 + i);
        program_start(3, 0, 4);
        wait_ready("wp_ready", 4 * TP);
        chk("wp_busy_cycles", low_total - t_snap, TP);
        cmd(8'h70);
        read_byte(q, oe); chk("status_wp_fail", q, 8'h41);
        wp_n = 1'b1;
        tick(3);
        read_start(3, 0);
        check_read(3, 0, PB);

        // Reset in the middle of a program
        for (int i = 0; i < 4; i++) buf_d[i] = 8'(8'h90 + i);
        program_start(9, 0, 4);
        valid[9] = 1'b0;
        tick(10);
        chk("rst_mid_busy", rb_n, 1'b0);
        t1 = low_total;
        cmd(8'hFF);
        wait_ready("rst_ready", 40);
        chk("rst_aborted", (low_total - t_snap) < TP, 1'b1);
        chk("rst_min_busy", (low_total - t1) >= TRS, 1'b1);
        chk("rst_max_busy", (low_total - t1) <= TRS + 8, 1'b1);
        cmd(8'h70);
        read_byte(q, oe); chk("status_after_rst", q, 8'hC0);
        read_start(5, 0);
        check_read(5, 0, PB);

        // Column wrap and deselected RE pulse
        for (int i = 0; i < PB; i++) buf_d[i] = 8'(8'hA0 + i);
        program_start(7, 0, PB);
        wait_ready("wrap_pg_ready", 4 * TP);
        read_start(7, PB - 1);
        check_read(7, PB - 1, 2);
        ce_n = 1'b1;
        tick(2);
        re_n = 1'b0;
        tick(4);
        @(negedge clk);
        chk("desel_q_oe", q_oe, 1'b0);
        chk("desel_flash_q", flash_q, 8'hAA);
        @(posedge clk); #1;
        re_n = 1'b1;
        tick(3);
        ce_n = 1'b0;
        tick(2);
        check_read(7, 1, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
